// File: rtl/sd_card_data_responder.sv
// sd_card_data_responder: card-side SD DAT[3:0] engine sourcing read blocks and sinking write blocks
// with per-line CRC16, CRC status token and busy signalling on DAT0.
module sd_card_data_responder #(
  parameter int BLKSIZE_W = 12,
  parameter int NAC       = 2,
  parameter int NCRC      = 2
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 start_read_i,
  input  logic                 start_write_i,
  input  logic                 abort_i,
  input  logic [BLKSIZE_W-1:0] blksize_i,
  input  logic [3:0]           dat_i,
  output logic [3:0]           dat_o,
  output logic [3:0]           dat_oe_o,
  input  logic [7:0]           tx_data_i,
  output logic                 tx_rd_o,
  output logic [7:0]           rx_data_o,
  output logic                 rx_we_o,
  input  logic                 busy_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 crc_err_o
);
  localparam int CW = BLKSIZE_W + 1;
  localparam logic [CW-1:0] ONE = CW'(1);
  typedef enum logic [3:0] {
    IDLE, RD_WAIT, RD_START, RD_DATA, RD_CRC, RD_END,
    WR_WAIT, WR_DATA, WR_CRC, WR_END, WR_GAP, WR_STATUS, WR_BUSY, WR_DONE
  } state_t;
  state_t               state;
  logic [BLKSIZE_W-1:0] blk;
  logic [CW-1:0]        cnt, nib_last;
  logic [3:0]           lo, din, crc_msb, tok;
  logic                 err, last_nib;
  logic [3:0][15:0]     crc, crc_n, crc_sh;
  assign nib_last = {blk, 1'b0} - ONE;
  assign last_nib = cnt == nib_last;
  assign busy_o   = state != IDLE;
  // Nibble entering the CRC this edge: sampled bus on writes, next driven nibble on reads
  assign din = (state == WR_DATA) ? dat_i :
               (state == RD_DATA && !cnt[0]) ? lo : tx_data_i[7:4];
  for (genvar g = 0; g < 4; g++) begin : g_crc
    assign crc_msb[g] = crc[g][15];
    assign crc_sh[g]  = {crc[g][14:0], 1'b0};
    assign crc_n[g]   = crc_sh[g] ^ ((crc[g][15] ^ din[g]) ? 16'h1021 : 16'h0000);
  end
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      blk       <= '0;
      cnt       <= '0;
      lo        <= '0;
      tok       <= '0;
      err       <= 1'b0;
      crc       <= '0;
      dat_o     <= 4'hF;
      dat_oe_o  <= 4'h0;
      tx_rd_o   <= 1'b0;
      rx_data_o <= 8'h00;
      rx_we_o   <= 1'b0;
      done_o    <= 1'b0;
      crc_err_o <= 1'b0;
    end else begin
      tx_rd_o   <= 1'b0;
      rx_we_o   <= 1'b0;
      rx_data_o <= 8'h00;
      done_o    <= 1'b0;
      crc_err_o <= 1'b0;
      if (abort_i) begin
        state    <= IDLE;
        dat_o    <= 4'hF;
        dat_oe_o <= 4'h0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            crc <= '0;
            err <= 1'b0;
            if ((start_read_i || start_write_i) && blksize_i != '0) begin
              blk      <= blksize_i;
              state    <= start_read_i ? RD_WAIT : WR_WAIT;
              dat_oe_o <= {4{start_read_i}};
            end
          end
          RD_WAIT: begin
            if (cnt == CW'(NAC - 1)) begin
              state   <= RD_START;
              dat_o   <= 4'h0;
              tx_rd_o <= 1'b1;
              cnt     <= '0;
            end else cnt <= cnt + ONE;
          end
          RD_START: begin
            state <= RD_DATA;
            dat_o <= din;
            lo    <= tx_data_i[3:0];
            crc   <= crc_n;
          end
          RD_DATA: begin
            if (last_nib) begin
              state <= RD_CRC;
              dat_o <= crc_msb;
              crc   <= crc_sh;
              cnt   <= '0;
            end else begin
              dat_o <= din;
              crc   <= crc_n;
              cnt   <= cnt + ONE;
              // fetch the next byte while its predecessor's low nibble is on the bus
              if (!cnt[0]) tx_rd_o <= (cnt + ONE) != nib_last;
              else lo <= tx_data_i[3:0];
            end
          end
          RD_CRC: begin
            if (cnt == CW'(15)) begin
              state  <= RD_END;
              dat_o  <= 4'hF;
              done_o <= 1'b1;
            end else begin
              dat_o <= crc_msb;
              crc   <= crc_sh;
              cnt   <= cnt + ONE;
            end
          end
          RD_END: begin
            state    <= IDLE;
            dat_oe_o <= 4'h0;
          end
          WR_WAIT: if (dat_i == 4'h0) state <= WR_DATA;
          WR_DATA: begin
            crc <= crc_n;
            if (cnt[0]) begin
              rx_data_o <= {lo, dat_i};
              rx_we_o   <= 1'b1;
            end else lo <= dat_i;
            if (last_nib) begin
              state <= WR_CRC;
              cnt   <= '0;
            end else cnt <= cnt + ONE;
          end
          WR_CRC: begin
            err <= err | (dat_i != crc_msb);
            crc <= crc_sh;
            if (cnt == CW'(15)) begin
              state <= WR_END;
              cnt   <= '0;
            end else cnt <= cnt + ONE;
          end
          WR_END: begin
            err   <= err | (dat_i != 4'hF);
            state <= WR_GAP;
          end
          WR_GAP: begin
            if (cnt == CW'(NCRC - 1)) begin
              state    <= WR_STATUS;
              dat_oe_o <= 4'h1;
              dat_o    <= 4'hE;
              tok      <= err ? 4'b1011 : 4'b0101;
              cnt      <= '0;
            end else cnt <= cnt + ONE;
          end
          WR_STATUS: begin
            if (cnt == CW'(4)) begin
              if (err) begin
                state     <= WR_DONE;
                dat_oe_o  <= 4'h0;
                dat_o     <= 4'hF;
                done_o    <= 1'b1;
                crc_err_o <= 1'b1;
              end else begin
                state <= WR_BUSY;
                dat_o <= 4'hE;
              end
            end else begin
              dat_o <= {3'b111, tok[3]};
              tok   <= {tok[2:0], 1'b0};
              cnt   <= cnt + ONE;
            end
          end
          WR_BUSY: begin
            if (!busy_i) begin
              state    <= WR_DONE;
              dat_oe_o <= 4'h0;
              dat_o    <= 4'hF;
              done_o   <= 1'b1;
            end
          end
          WR_DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
